// File: rtl/tmds_channel_decoder.sv
`timescale 1ns / 1ps
`default_nettype none
// tmds_channel_decoder: one TMDS receive channel with word alignment (bitslip) FSM.
// Revision 1.0 - initial release.
module tmds_channel_decoder #(
  parameter int TOKEN_RUN      = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_SETTLE    = 4,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       i_pix_clk,
  input  logic       i_rst,
  input  logic [9:0] i_tmds_word,
  output logic       o_bitslip,
  output logic       o_aligned,
  output logic       o_de,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl
);

  localparam int MAX_A = (TOKEN_RUN > SEARCH_TIMEOUT) ? TOKEN_RUN : SEARCH_TIMEOUT;
  localparam int MAX_B = (SLIP_SETTLE > LOSS_TIMEOUT) ? SLIP_SETTLE : LOSS_TIMEOUT;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(TOKEN_RUN - 1);
  localparam logic [CNT_W-1:0] TIMER_LAST  = CNT_W'(SEARCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SLIP_SETTLE - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_TIMEOUT - 1);

  localparam logic [1:0] SEARCH    = 2'd0;
  localparam logic [1:0] SLIP_WAIT = 2'd1;
  localparam logic [1:0] LOCKED    = 2'd2;

  logic [9:0]       word_q;
  logic             is_token;
  logic [1:0]       token_ctrl;
  logic [7:0]       bits_b;
  logic [7:0]       data_dec;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] run_cnt, run_nx;
  logic [CNT_W-1:0] search_timer, search_nx;
  logic [CNT_W-1:0] settle_cnt, settle_nx;
  logic [CNT_W-1:0] loss_cnt, loss_nx;
  logic             slip_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      word_q <= '0;
    end else begin
      word_q <= i_tmds_word;
    end
  end

  always_comb begin
    is_token   = 1'b1;
    token_ctrl = 2'b00;
    case (word_q)
      10'b1101010100: token_ctrl = 2'b00;
      10'b0010101011: token_ctrl = 2'b01;
      10'b0101010100: token_ctrl = 2'b10;
      10'b1010101011: token_ctrl = 2'b11;
      default:        is_token   = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR chain
  assign bits_b   = word_q[9] ? ~word_q[7:0] : word_q[7:0];
  assign data_dec = {bits_b[7:1] ^ bits_b[6:0] ^ {7{~word_q[8]}}, bits_b[0]};

  always_comb begin
    state_nx  = state;
    run_nx    = run_cnt;
    search_nx = search_timer;
    settle_nx = settle_cnt;
    loss_nx   = loss_cnt;
    slip_nx   = 1'b0;
    case (state)
      SEARCH: begin
        run_nx    = is_token ? sat_inc(run_cnt) : '0;
        search_nx = sat_inc(search_timer);
        // Lock is checked first so a simultaneous timeout never slips
        if (is_token && (run_cnt >= RUN_LAST)) begin
          state_nx  = LOCKED;
          run_nx    = '0;
          search_nx = '0;
          loss_nx   = '0;
        end else if (search_timer >= TIMER_LAST) begin
          state_nx  = SLIP_WAIT;
          slip_nx   = 1'b1;
          run_nx    = '0;
          search_nx = '0;
          settle_nx = '0;
        end
      end
      SLIP_WAIT: begin
        settle_nx = sat_inc(settle_cnt);
        if (settle_cnt >= SETTLE_LAST) begin
          state_nx  = SEARCH;
          settle_nx = '0;
          run_nx    = '0;
          search_nx = '0;
        end
      end
      LOCKED: begin
        loss_nx = is_token ? '0 : sat_inc(loss_cnt);
        if (!is_token && (loss_cnt >= LOSS_LAST)) begin
          state_nx  = SEARCH;
          loss_nx   = '0;
          run_nx    = '0;
          search_nx = '0;
        end
      end
      default: begin
        state_nx  = SEARCH;
        run_nx    = '0;
        search_nx = '0;
        settle_nx = '0;
        loss_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      state        <= SEARCH;
      run_cnt      <= '0;
      search_timer <= '0;
      settle_cnt   <= '0;
      loss_cnt     <= '0;
    end else begin
      state        <= state_nx;
      run_cnt      <= run_nx;
      search_timer <= search_nx;
      settle_cnt   <= settle_nx;
      loss_cnt     <= loss_nx;
    end
  end

  // Words are squashed on the edge where lock drops as well as while unlocked
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      o_bitslip <= 1'b0;
      o_de      <= 1'b0;
      o_data    <= '0;
      o_ctrl    <= '0;
    end else begin
      o_bitslip <= slip_nx;
      if ((state == LOCKED) && (state_nx == LOCKED)) begin
        if (is_token) begin
          o_de   <= 1'b0;
          o_data <= '0;
          o_ctrl <= token_ctrl;
        end else begin
          o_de   <= 1'b1;
          o_data <= data_dec;
        end
      end else begin
        o_de   <= 1'b0;
        o_data <= '0;
        o_ctrl <= '0;
      end
    end
  end

  assign o_aligned = (state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
`timescale 1ns / 1ps
`default_nettype none
// tb_tmds_channel_decoder: directed + randomized checks against a behavioural TMDS receive model.
// Revision 1.0 - initial release.
module tb_tmds_channel_decoder;

  localparam int TOKEN_RUN      = 8;
  localparam int SEARCH_TIMEOUT = 2048;
  localparam int SLIP_SETTLE    = 4;
  localparam int LOSS_TIMEOUT   = 4096;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  logic       clk;
  logic       rst;
  logic [9:0] word;
  logic       bitslip;
  logic       aligned;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;

  int         checks;
  int         errors;
  logic [9:0] last_w;
  logic [9:0] prev_w;
  logic [1:0] model_ctrl;

  tmds_channel_decoder #(
    .TOKEN_RUN     (TOKEN_RUN),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .SLIP_SETTLE   (SLIP_SETTLE),
    .LOSS_TIMEOUT  (LOSS_TIMEOUT)
  ) dut (
    .i_pix_clk  (clk),
    .i_rst      (rst),
    .i_tmds_word(word),
    .o_bitslip  (bitslip),
    .o_aligned  (aligned),
    .o_de       (de),
    .o_data     (data),
    .o_ctrl     (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic int tok_idx(input logic [9:0] w);
    if (w == TOK0) return 0;
    if (w == TOK1) return 1;
    if (w == TOK2) return 2;
    if (w == TOK3) return 3;
    return -1;
  endfunction

  function automatic logic [9:0] tok_of(input int i);
    case (i)
      0:       return TOK0;
      1:       return TOK1;
      2:       return TOK2;
      default: return TOK3;
    endcase
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] q);
    logic [7:0] b;
    logic [7:0] d;
    b    = q[9] ? ~q[7:0] : q[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++) d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    return d;
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [19:0] t;
    t = {w, w} << n;
    return t[19:10];
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom);
    for (int n = 0; n < 8 && tok_idx(w) >= 0; n++) w = 10'($urandom);
    if (tok_idx(w) >= 0) w = 10'h1FF;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One word per clock; outputs after the edge reflect the word driven one step earlier
  task automatic drive(input logic [9:0] w);
    word = w;
    @(posedge clk);
    #1;
    prev_w = last_w;
    last_w = w;
  endtask

  task automatic chk_idle(input string tag, input logic exp_al);
    chk(tag, 32'({aligned, bitslip, de, data, ctrl}), 32'({exp_al, 12'h000}));
  endtask

  task automatic chk_locked(input string tag);
    logic [12:0] e;
    int          t;
    t = tok_idx(prev_w);
    if (t >= 0) begin
      model_ctrl = 2'(t);
      e = {1'b1, 1'b0, 1'b0, 8'h00, model_ctrl};
    end else begin
      e = {1'b1, 1'b0, 1'b1, decode(prev_w), model_ctrl};
    end
    chk(tag, 32'({aligned, bitslip, de, data, ctrl}), 32'(e));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(10'h000);
    drive(10'h000);
    chk_idle("reset_outs", 1'b0);
    rst    = 1'b0;
    last_w = 10'h000;
  endtask

  task automatic lock_from_reset(input string tag);
    for (int k = 1; k <= TOKEN_RUN + 1; k++) begin
      drive(TOK0);
      chk_idle(tag, 1'(k == TOKEN_RUN + 1));
    end
    model_ctrl = 2'b00;
  endtask

  int   pulses, first_pulse, last_pulse, lock_step, offset, de_seen, got_slip;
  logic [9:0] w;

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    word       = 10'h000;
    last_w     = 10'h000;
    prev_w     = 10'h000;
    model_ctrl = 2'b00;

    do_reset();
    lock_from_reset("lock_seq");

    // Directed data words
    drive(10'h1FF); chk_locked("ctrl_after_lock");
    drive(10'h300); chk_locked("dec_1ff");
    chk("dec_1ff_const", 32'(data), 32'h01);
    drive(10'h200); chk_locked("dec_300");
    drive(TOK3);    chk_locked("dec_200");
    chk("dec_200_const", 32'(data), 32'hFF);
    drive(TOK1);    chk_locked("ctrl_11");
    drive(TOK2);    chk_locked("ctrl_01");

    // Randomized locked traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) w = tok_of(int'($urandom_range(0, 3)));
      else w = rand_data();
      drive(w);
      chk_locked("rand_locked");
    end

    // Loss of lock after LOSS_TIMEOUT data words
    drive(TOK2); chk_locked("loss_pre");
    for (int j = 1; j <= LOSS_TIMEOUT; j++) begin
      drive(rand_data());
      chk_locked("loss_hold");
    end
    drive(rand_data()); chk_idle("loss_drop", 1'b0);
    for (int j = 0; j < 3; j++) begin
      drive(rand_data()); chk_idle("loss_after", 1'b0);
    end

    // 7 tokens, a data word, then a full run
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      if (k == 8) drive(10'h1FF);
      else drive(TOK0);
      chk_idle("broken_run", 1'(k == 17));
    end

    // Alignment by bitslip from a 3-bit rotated stream
    do_reset();
    offset = 3; pulses = 0; first_pulse = 0; last_pulse = 0; lock_step = 0; de_seen = 0;
    for (int k = 1; k <= 8000 && lock_step == 0; k++) begin
      drive(rotl(TOK0, offset));
      if (de) de_seen++;
      if (bitslip) begin
        if (pulses == 0) first_pulse = k;
        else chk("slip_gap", 32'((k - last_pulse) >= SEARCH_TIMEOUT + SLIP_SETTLE), 32'd1);
        pulses++;
        last_pulse = k;
        if (offset > 0) offset--;
      end
      if (aligned) lock_step = k;
    end
    chk("slip_pulses", 32'(pulses), 32'd3);
    chk("slip_first", 32'(first_pulse >= SEARCH_TIMEOUT - 1 && first_pulse <= SEARCH_TIMEOUT + 1), 32'd1);
    chk("slip_locked", 32'(lock_step != 0), 32'd1);
    chk("slip_lock_lat", 32'(lock_step > last_pulse && (lock_step - last_pulse) <= SLIP_SETTLE + TOKEN_RUN + 1), 32'd1);
    chk("slip_de_quiet", 32'(de_seen), 32'd0);

    // Reset while in SLIP_WAIT
    do_reset();
    got_slip = 0;
    for (int k = 1; k <= SEARCH_TIMEOUT + 50 && got_slip == 0; k++) begin
      drive(10'h1FF);
      if (bitslip) got_slip = 1;
    end
    chk("slip_seen", 32'(got_slip), 32'd1);
    rst = 1'b1;
    drive(10'h1FF);
    chk_idle("rst_slipwait", 1'b0);
    rst = 1'b0;
    last_w = 10'h000;
    lock_from_reset("relock_after_slip_rst");

    // Reset while locked and carrying data
    drive(10'h1FF); chk_locked("pre_rst_data");
    drive(10'h2AB); chk_locked("pre_rst_data2");
    rst = 1'b1;
    drive(10'h155);
    chk_idle("rst_locked", 1'b0);
    rst = 1'b0;
    last_w = 10'h000;
    lock_from_reset("relock_after_lock_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
